// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven load/shift/capture controller for an external universal shift register.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_load,
    output logic             sr_shift_left,
    output logic             sr_shift_right,
    output logic [WIDTH-1:0] sr_parallel_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, RESP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining;
    logic             dir;

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = cmd_valid ? LOAD : IDLE;
            LOAD:    state_next = (remaining == '0) ? CAPTURE : SHIFT;
            SHIFT:   state_next = (remaining == CNT_W'(1)) ? CAPTURE : SHIFT;
            CAPTURE: state_next = RESP;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Controls are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            dir            <= 1'b0;
            sr_load        <= 1'b0;
            sr_shift_left  <= 1'b0;
            sr_shift_right <= 1'b0;
            sr_parallel_in <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
        end else begin
            state          <= state_next;
            sr_load        <= state_next == LOAD;
            sr_shift_left  <= state_next == SHIFT && !dir;
            sr_shift_right <= state_next == SHIFT && dir;
            rsp_valid      <= state_next == RESP;
            if (state == IDLE && cmd_valid) begin
                dir            <= cmd_dir;
                remaining      <= cmd_count;
                sr_parallel_in <= cmd_data;
            end
            if (state == SHIFT) remaining <= remaining - CNT_W'(1);
            if (state == CAPTURE) rsp_data <= sr_q;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: drives directed and random commands against a zero-fill shift register and
// checks cycle timelines and results against an arithmetic reference.
module tb_shift_sequencer;
    logic       clk = 1'b0, reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_dir = 1'b0, rsp_ready = 1'b0;
    logic [3:0] cmd_count = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, sr_load, sr_shift_left, sr_shift_right, rsp_valid, busy;
    logic [7:0] sr_parallel_in, rsp_data;
    logic [7:0] sr_q = '0;
    int         checks = 0, errors = 0;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_count(cmd_count), .cmd_data(cmd_data), .sr_load(sr_load), .sr_shift_left(sr_shift_left),
        .sr_shift_right(sr_shift_right), .sr_parallel_in(sr_parallel_in), .sr_q(sr_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Zero-fill universal shift register datapath.
    always @(posedge clk) begin
        if (sr_load) sr_q <= sr_parallel_in;
        else if (sr_shift_left) sr_q <= {sr_q[6:0], 1'b0};
        else if (sr_shift_right) sr_q <= {1'b0, sr_q[7:1]};
    end

    wire [2:0] ctrl = {sr_load, sr_shift_left, sr_shift_right};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert ($countones(ctrl) <= 1) else begin
                errors++;
                $error("FAIL exclusive observed=%b expected=onehot0", ctrl);
            end
        end
    end

    function automatic logic [7:0] expect_result(input logic [7:0] d, input logic dr, input int n);
        return dr ? d >> n : d << n;
    endfunction

    // One full command: accept, load, n shifts, capture, response held for `hold` extra cycles.
    task automatic run_cmd(input logic [7:0] d, input logic dr, input logic [3:0] n, input int hold,
                           input logic pend);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = d; cmd_dir = dr; cmd_count = n; rsp_ready = 1'b0;
        chk("ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_data = 8'($urandom); cmd_dir = 1'($urandom); cmd_count = 4'($urandom);
        chk("load_ctrl", ctrl, 3'b100);
        chk("load_data", sr_parallel_in, d);
        chk("load_busy", {busy, cmd_ready}, 2'b10);
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clk); #1;
            chk("shift_ctrl", ctrl, dr ? 3'b001 : 3'b010);
        end
        @(posedge clk); #1;
        chk("capture", {ctrl, rsp_valid}, 4'b0000);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, expect_result(d, dr, int'(n)));
        for (int i = 0; i < hold; i++) begin
            if (pend) begin cmd_valid = 1'b1; cmd_data = 8'($urandom); end
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, expect_result(d, dr, int'(n)));
            chk("hold_ctrl", {ctrl, cmd_ready}, 4'b0000);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("after_hs", {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        #1;
        chk("rst_ctrl", {ctrl, rsp_valid, busy, cmd_ready}, 6'b000001);
        chk("rst_data", {sr_parallel_in, rsp_data}, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_cmd(8'hAA, 1'b0, 4'd1, 0, 1'b0);
        chk("left_1", rsp_data, 8'h54);
        run_cmd(8'hAA, 1'b1, 4'd3, 0, 1'b0);
        chk("right_3", rsp_data, 8'h15);
        run_cmd(8'h3C, 1'b0, 4'd0, 0, 1'b0);
        chk("zero_cnt", rsp_data, 8'h3C);
        run_cmd(8'hC3, 1'b1, 4'd2, 4, 1'b1);
        run_cmd(8'h5A, 1'b0, 4'd2, 0, 1'b0);
        chk("second_cmd", rsp_data, 8'h68);
        // Reset after two of five shifts.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_dir = 1'b0; cmd_count = 4'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        chk("pre_rst_shift", ctrl, 3'b010);
        #3 reset = 1'b1;
        #1;
        chk("midrst_ctrl", {ctrl, rsp_valid, busy, cmd_ready}, 6'b000001);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_ignores_valid", {ctrl, busy}, 4'b0000);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("no_rsp", {rsp_valid, busy}, 2'b00);
        end
        run_cmd(8'h81, 1'b0, 4'd1, 0, 1'b0);
        chk("post_rst", rsp_data, 8'h02);
        for (int k = 0; k < 20; k++)
            run_cmd(8'($urandom), 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
